// File: rtl/riscv_pkg.sv
// Base RISC-V widths shared by the core.
package riscv_pkg;
    localparam int MXLEN = 32;
endpackage

// File: rtl/riscv_privileged_pkg.sv
// Machine-mode CSR bus types.
package riscv_privileged_pkg;
    typedef logic [11:0] csr_address_t;

    typedef enum logic [1:0] {
        NONE           = 2'd0,
        READ_ONLY      = 2'd1,
        WRITE_ONLY     = 2'd2,
        WRITE_AND_READ = 2'd3
    } csr_command_t;
endpackage

// File: rtl/csr_access_unit_if.sv
// Bundles the issue-side request, the CSR responder bus and the write-back
// handshake of csr_access_unit. The slave modport is the unit itself; the
// master modport is everything around it.
interface csr_access_unit_if;
    import riscv_pkg::*;
    import riscv_privileged_pkg::*;

    logic               req_valid_i;
    logic               req_ready_o;
    logic [2:0]         req_funct3_i;
    csr_address_t       req_csr_address_i;
    logic [4:0]         req_rs1_index_i;
    logic [MXLEN-1:0]   req_rs1_data_i;
    logic [4:0]         req_rd_index_i;
    logic               flush_i;

    csr_address_t       csr_address_o;
    csr_command_t       csr_command_o;
    logic [MXLEN-1:0]   csr_write_data_o;
    logic [MXLEN-1:0]   csr_read_data_i;
    logic               csr_read_data_valid_i;

    logic               wb_valid_o;
    logic               wb_ready_i;
    logic [4:0]         wb_rd_index_o;
    logic [MXLEN-1:0]   wb_data_o;
    logic               wb_illegal_o;

    modport slave (
        input  req_valid_i, req_funct3_i, req_csr_address_i, req_rs1_index_i,
               req_rs1_data_i, req_rd_index_i, flush_i,
               csr_read_data_i, csr_read_data_valid_i, wb_ready_i,
        output req_ready_o, csr_address_o, csr_command_o, csr_write_data_o,
               wb_valid_o, wb_rd_index_o, wb_data_o, wb_illegal_o
    );

    modport master (
        output req_valid_i, req_funct3_i, req_csr_address_i, req_rs1_index_i,
               req_rs1_data_i, req_rd_index_i, flush_i,
               csr_read_data_i, csr_read_data_valid_i, wb_ready_i,
        input  req_ready_o, csr_address_o, csr_command_o, csr_write_data_o,
               wb_valid_o, wb_rd_index_o, wb_data_o, wb_illegal_o
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr initiator: takes one decoded CSR instruction, splits it into
// read / write commands toward the CSR file, performs the read-modify-write
// and returns the old CSR value (or an illegal-instruction flag) to rd.
module csr_access_unit
    import riscv_pkg::*;
    import riscv_privileged_pkg::*;
#(
    parameter bit CHECK_READ_ONLY = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    csr_access_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RW    = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    // funct3[1:0] encodings; funct3[2] selects the immediate forms
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t           state_q, state_d;
    csr_address_t     addr_q, addr_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             do_read_q, do_read_d;
    logic             do_write_q, do_write_d;
    logic [MXLEN-1:0] src_q, src_d;
    logic [MXLEN-1:0] old_q, old_d;

    csr_command_t     csr_cmd;
    logic [MXLEN-1:0] csr_wdata;

    function automatic logic [MXLEN-1:0] rmw_value(input logic [1:0]       op,
                                                  input logic [MXLEN-1:0] old,
                                                  input logic [MXLEN-1:0] src);
        case (op)
            OP_RS:   rmw_value = old | src;
            OP_RC:   rmw_value = old & ~src;
            default: rmw_value = src;
        endcase
    endfunction

    // Next-state, request capture and command bus decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        do_read_d  = do_read_q;
        do_write_d = do_write_q;
        src_d      = src_q;
        old_d      = old_q;
        csr_cmd    = NONE;
        csr_wdata  = '0;

        case (state_q)
            IDLE: begin
                // A flush in the same cycle kills the offered instruction
                if (bus.req_valid_i && !bus.flush_i) begin
                    addr_d     = bus.req_csr_address_i;
                    rd_d       = bus.req_rd_index_i;
                    op_d       = bus.req_funct3_i[1:0];
                    src_d      = bus.req_funct3_i[2] ? {{(MXLEN-5){1'b0}}, bus.req_rs1_index_i}
                                                     : bus.req_rs1_data_i;
                    old_d      = '0;
                    illegal_d  = 1'b0;
                    do_read_d  = !((bus.req_funct3_i[1:0] == OP_RW) && (bus.req_rd_index_i == 5'd0));
                    do_write_d = (bus.req_funct3_i[1:0] == OP_RW) || (bus.req_rs1_index_i != 5'd0);

                    if (bus.req_funct3_i[1:0] == 2'b00) begin
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end else if (do_write_d && CHECK_READ_ONLY &&
                                 (bus.req_csr_address_i[11:10] == 2'b11)) begin
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end else if (bus.req_funct3_i[1:0] == OP_RW) begin
                        state_d = do_read_d ? RW : WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            RW: begin
                csr_cmd   = WRITE_AND_READ;
                csr_wdata = src_q;
                old_d     = bus.csr_read_data_i;
                // The write has already been presented; a flush only drops the response
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    illegal_d = !bus.csr_read_data_valid_i;
                    state_d   = RESP;
                end
            end

            READ: begin
                csr_cmd = READ_ONLY;
                old_d   = bus.csr_read_data_i;
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (!bus.csr_read_data_valid_i) begin
                    illegal_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    state_d = do_write_q ? WRITE : RESP;
                end
            end

            WRITE: begin
                csr_cmd   = WRITE_ONLY;
                csr_wdata = rmw_value(op_q, old_q, src_q);
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    illegal_d = !bus.csr_read_data_valid_i;
                    state_d   = RESP;
                end
            end

            RESP: begin
                if (bus.flush_i || bus.wb_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state and the fields visible on outputs after reset
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            illegal_q  <= 1'b0;
            do_read_q  <= 1'b0;
            do_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            illegal_q  <= illegal_d;
            do_read_q  <= do_read_d;
            do_write_q <= do_write_d;
        end
    end

    // Operand and captured old value; only observed through state-gated outputs
    always_ff @(posedge clock_i) begin
        src_q <= src_d;
        old_q <= old_d;
    end

    assign bus.req_ready_o      = (state_q == IDLE);
    assign bus.csr_address_o    = addr_q;
    assign bus.csr_command_o    = csr_cmd;
    assign bus.csr_write_data_o = csr_wdata;
    assign bus.wb_valid_o       = (state_q == RESP);
    assign bus.wb_rd_index_o    = rd_q;
    assign bus.wb_illegal_o     = (state_q == RESP) && illegal_q;
    assign bus.wb_data_o        = ((state_q == RESP) && do_read_q && !illegal_q) ? old_q : '0;

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Core-side initiator for the machine-mode CSR file. It accepts one decoded Zicsr instruction at a time from the issue stage and splits it into read and/or write commands on the `csr_address` / `csr_command` / `csr_write_data` bus. It computes the read-modify-write value, checks the responder's valid flag, and returns rd write-back data or an illegal-instruction flag. It sits between the execute stage and `exception_handler`; the responder's read data is combinational and its writes take effect at the clock edge.

## Interface
- `CHECK_READ_ONLY`, default 1: when 1, a write to an address with bits [11:10] == 2'b11 is flagged illegal and no command is issued.
- Widths come from `riscv_pkg` (`MXLEN`); types come from `riscv_privileged_pkg` (`csr_address_t`, `csr_command_t` with values NONE, READ_ONLY, WRITE_ONLY, WRITE_AND_READ).

Ports:
- `clock_i`  in  1  single clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  instruction offered.
- `req_ready_o`  out  1  unit idle and can accept.
- `req_funct3_i`  in  3  Zicsr funct3.
- `req_csr_address_i`  in  csr_address_t  target CSR.
- `req_rs1_index_i`  in  5  rs1 index, or uimm for the immediate forms.
- `req_rs1_data_i`  in  MXLEN  rs1 value; ignored for the immediate forms.
- `req_rd_index_i`  in  5  destination register.
- `flush_i`  in  1  pipeline kill.
- `csr_address_o`  out  csr_address_t  to responder.
- `csr_command_o`  out  csr_command_t  to responder.
- `csr_write_data_o`  out  MXLEN  to responder.
- `csr_read_data_i`  in  MXLEN  from responder (combinational).
- `csr_read_data_valid_i`  in  1  address exists and privilege is OK.
- `wb_valid_o`  out  1  result available.
- `wb_ready_i`  in  1  write-back accepts.
- `wb_rd_index_o`  out  5  destination register.
- `wb_data_o`  out  MXLEN  old CSR value.
- `wb_illegal_o`  out  1  raise illegal-instruction; rd is not written.

## Operation

States are IDLE, RW, READ, WRITE and RESP.

**Accept.** A request is accepted when `req_valid_i && req_ready_o`. On acceptance the unit latches all request fields.
- Source operand is `rs1_data` for funct3 001/010/011, and `{zero, uimm}` (zero-extended to MXLEN) for 101/110/111.
- funct3 000 or 100 goes directly to RESP with `wb_illegal_o`=1.

**Effect flags.**
- `do_read` = 0 only when the op is CSRRW/CSRRWI and rd == 0; otherwise 1.
- `do_write` = 0 only when the op is CSRRS/CSRRC/CSRRSI/CSRRCI and rs1/uimm == 0; otherwise 1.
- If `do_write` && `CHECK_READ_ONLY` && address[11:10] == 2'b11: go to RESP with the illegal flag set; no command is issued.

**Next state from IDLE.**
- CSRRW/CSRRWI with `do_read`: RW, which drives WRITE_AND_READ with the source operand and captures the old value.
- CSRRW/CSRRWI without `do_read`: WRITE.
- All other ops: READ, which drives READ_ONLY and captures `csr_read_data_i` into `old_q`.

**READ exit.** The unit goes to WRITE if `do_write`, otherwise to RESP.

**WRITE data.**
- RW ops: the source operand.
- RS ops: `old_q | src`.
- RC ops: `old_q & ~src`.

**Valid check.** In RW, READ and WRITE, `csr_read_data_valid_i` is sampled at the cycle's end. If it is 0, the unit latches the illegal flag, skips any pending WRITE, and goes to RESP.

**RESP.**
- `wb_valid_o`=1, `wb_data_o` = `old_q` (0 if `!do_read` or illegal), `wb_illegal_o` = the flag.
- The outputs hold until `wb_ready_i`; the unit then returns to IDLE.

**Command bus in IDLE and RESP.** `csr_command_o`=NONE, `csr_write_data_o`=0, `csr_address_o` = the last latched address.

**Flush.**
- `flush_i` in READ or RESP: go to IDLE next cycle. No write is issued and `wb_valid_o` drops.
- `flush_i` in RW or WRITE: the write still commits at that edge and the unit then goes to IDLE with no response.
- `flush_i` in IDLE: the request is not accepted that cycle.

## Timing
- Reset values: state IDLE, `req_ready_o`=1, `csr_command_o`=NONE, `csr_address_o`=0, `csr_write_data_o`=0, `wb_valid_o`=0, `wb_data_o`=0, `wb_illegal_o`=0, `wb_rd_index_o`=0.
- `req_ready_o` = (state == IDLE); it is combinational from state only.
- Latency from the accept edge to the first `wb_valid_o` cycle:
  - RW/WRITE-only paths: 2 cycles.
  - READ only: 2 cycles.
  - READ + WRITE: 3 cycles.
  - Illegal at decode: 1 cycle.
- The responder updates the CSR at the rising edge that ends the WRITE/RW cycle. A new request is accepted no earlier than the cycle after the RESP handshake, so back-to-back ops observe prior writes.
- Reset mid-operation returns the unit to IDLE immediately. Any write not yet clocked is lost.

## Test plan
- CSRRW `mscratch` (0x340), rs1=0xDEAD_BEEF, rd=5, prior value 0x0: one RW cycle with WRITE_AND_READ, then `wb_valid_o` with `wb_data_o`=0x0, rd=5. A following CSRRS rs1=x0 returns 0xDEAD_BEEF and issues no WRITE cycle.
- CSRRSI `mie` (0x304) uimm=0x8 with prior `mie`=0x80: READ then WRITE with data 0x88, `wb_data_o`=0x80. Repeat with CSRRCI uimm=0x8: write data 0x80.
- CSRRW with rd=0 to `mepc` (0x341): no READ cycle, one WRITE_ONLY cycle, `wb_data_o`=0, `wb_illegal_o`=0.
- Access to 0x7C0 (responder valid=0): READ cycle, then RESP with `wb_illegal_o`=1 and no WRITE_ONLY ever driven. funct3=100 gives illegal after 1 cycle with command NONE throughout. CSRRW to 0xF11 gives illegal with no command issued.
- Hold `wb_ready_i`=0 for 4 cycles in RESP: outputs stable and `req_ready_o`=0. Assert `flush_i` in READ: IDLE next cycle, no write, no `wb_valid_o`.
- Deassert `reset_ni` during WRITE: all outputs take their reset values within the same cycle, and `req_ready_o`=1 after release.
